fetch_unit: RTL and testbench

Instruction-fetch stage directly downstream of pcreg. It takes the current PC from pcreg, issues a read to instruction memory over a req/ack handshake, and buffers each returned instruction with its PC in a 2-entry FIFO for decode. It drives pcreg's enable so the PC advances only when a fetch completes or a redirect (flush) occurs.

---
 rtl/mips_fetch_pkg.sv | 21 ++
 rtl/fetch_fifo.sv | 73 +++++++
 rtl/fetch_unit.sv | 133 +++++++++++++
 tb/tb_fetch_unit.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_fetch_pkg.sv
// mips_fetch_pkg: shared definitions for the instruction-fetch stage.
//   DEF_ADDR_W / DEF_DATA_W : default PC and instruction widths
//   fetch_state_t           : fetch sequencer states (IDLE / REQ / DROP)
//   fetch_entry_t           : one buffered fetch result {pc, inst}
package mips_fetch_pkg;

  localparam int unsigned DEF_ADDR_W = 32;
  localparam int unsigned DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // buffer full (or just out of reset), no request
    ST_REQ  = 2'd1,  // requesting the instruction at pc_in
    ST_DROP = 2'd2   // flushed mid-request; finish it and discard the data
  } fetch_state_t;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] pc;
    logic [DEF_DATA_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry synchronous FIFO holding fetched {pc, inst} words.
// Ports:
//   clk, rst     : rising-edge clock, asynchronous active-low reset
//   push/wr_data : write wr_data at the tail
//   pop          : discard the head entry
//   clear        : empty the FIFO; overrides push and pop
//   count        : current occupancy (0..DEPTH)
//   count_nxt    : occupancy after this edge (lets the caller look ahead)
//   head_data    : registered head entry, meaningful while count != 0
module fetch_fifo
  import mips_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = DEF_ADDR_W + DEF_DATA_W,
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [WIDTH-1:0] wr_data,
  output logic [CW-1:0]    count,
  output logic [CW-1:0]    count_nxt,
  output logic [WIDTH-1:0] head_data
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    count_q;

  always_comb begin
    count_nxt = count_q;
    if (clear) begin
      count_nxt = '0;
    end else begin
      count_nxt = count_q + CW'(push) - CW'(pop);
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      count_q <= count_nxt;
      if (clear) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) begin
          mem[wr_ptr] <= wr_data;
          wr_ptr      <= wr_ptr + 1'b1;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + 1'b1;
        end
      end
    end
  end

  assign count     = count_q;
  assign head_data = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage between pcreg and decode.
// Issues one imem read per PC over a req/ack handshake, buffers each
// {pc, inst} result in a small FIFO and advances pcreg (pc_ena) only on a
// completed fetch or a redirect.
// Ports:
//   clk, rst                     : rising-edge clock, async active-low reset
//   pc_in                        : current PC from pcreg
//   pc_ena                       : pcreg load enable
//   flush                        : redirect; next-PC mux selects the target
//   imem_req/imem_addr           : instruction memory request and address
//   imem_ack/imem_rdata          : request completion and returned word
//   inst_valid/inst_ready        : head handshake towards decode
//   inst_out/inst_pc             : head instruction and its PC
// All outputs are forced to 0 while rst is low.
module fetch_unit
  import mips_fetch_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_in,
  output logic              pc_ena,
  input  logic              flush,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] inst_out,
  output logic [ADDR_W-1:0] inst_pc
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned EW = ADDR_W + DATA_W;

  fetch_state_t      state;
  fetch_state_t      state_nxt;
  logic [ADDR_W-1:0] drop_addr;
  logic [ADDR_W-1:0] drop_addr_nxt;

  logic              push;
  logic              pop;
  logic              has_room;
  logic [CW-1:0]     count;
  logic [CW-1:0]     cnt_nxt;
  logic [EW-1:0]     head;

  // Buffer control. A flush clears the FIFO and blocks the push, so the
  // data of an ack coincident with a flush is discarded.
  assign push = (state == ST_REQ) && imem_ack && !flush;
  assign pop  = inst_valid && inst_ready;

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .clear     (flush),
    .wr_data   ({pc_in, imem_rdata}),
    .count     (count),
    .count_nxt (cnt_nxt),
    .head_data (head)
  );

  // Looking at the post-edge occupancy lets a pop at full restart the
  // request stream in the very cycle the entry leaves.
  assign has_room = (cnt_nxt < CW'(DEPTH));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      drop_addr <= '0;
    end else begin
      state     <= state_nxt;
      drop_addr <= drop_addr_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    drop_addr_nxt = drop_addr;
    case (state)
      ST_IDLE: begin
        if (has_room) begin
          state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        if (flush) begin
          // An unfinished request cannot be withdrawn: remember its
          // address so imem_addr stays stable until the ack arrives.
          if (!imem_ack) begin
            state_nxt     = ST_DROP;
            drop_addr_nxt = pc_in;
          end
        end else if (imem_ack && !has_room) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_DROP: begin
        if (imem_ack) begin
          state_nxt = ST_REQ;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    imem_addr = '0;
    if (rst) begin
      case (state)
        ST_REQ:  imem_addr = pc_in;
        ST_DROP: imem_addr = drop_addr;
        default: imem_addr = '0;
      endcase
    end
  end

  assign imem_req   = rst && (state != ST_IDLE);
  assign pc_ena     = rst && (flush || ((state == ST_REQ) && imem_ack));
  assign inst_valid = rst && (count != '0);
  assign inst_pc    = rst ? head[EW-1 -: ADDR_W] : '0;
  assign inst_out   = rst ? head[DATA_W-1:0]     : '0;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  import mips_fetch_pkg::*;

  localparam int unsigned DEPTH = 2;
  localparam logic [31:0] PC0   = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pc_in;
  logic        pc_ena;
  logic        flush = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fetch_unit #(
    .ADDR_W (32),
    .DATA_W (32),
    .DEPTH  (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pc_in      (pc_in),
    .pc_ena     (pc_ena),
    .flush      (flush),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .inst_out   (inst_out),
    .inst_pc    (inst_pc)
  );

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // pcreg with its next-PC mux: PC+4, or the redirect target on flush.
  logic [31:0] pc_q;
  logic [31:0] target = 32'h0040_0100;
  assign pc_in = pc_q;
  always @(posedge clk or negedge rst) begin
    if (!rst)        pc_q <= PC0;
    else if (pc_ena) pc_q <= flush ? target : pc_q + 32'd4;
  end

  // Instruction memory: acks after 'lat' waiting cycles (0 = same cycle).
  int unsigned wcnt;
  int unsigned lat_rand;
  int unsigned lat_fixed = 0;
  logic        rand_mode = 1'b0;
  assign imem_ack   = imem_req && (wcnt >= (rand_mode ? lat_rand : lat_fixed));
  assign imem_rdata = mem_fn(imem_addr);
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      wcnt     <= 0;
      lat_rand <= 0;
    end else if (imem_req && !imem_ack) begin
      wcnt <= wcnt + 1;
    end else begin
      wcnt <= 0;
      if (imem_ack) lat_rand <= ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0;
    end
  end

  // Reference model: the buffer is a queue of {pc, inst}. A request is
  // outstanding whenever a discarded fetch is still pending or the buffer
  // has room, except in the first cycle after reset.
  fetch_entry_t mq[$];
  logic         m_drop = 1'b0;
  logic         m_warm = 1'b0;
  logic [31:0]  m_drop_pc = '0;
  logic         m_req;
  logic         m_fetch;
  logic [31:0]  m_addr;

  always @(negedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete();
      m_drop    = 1'b0;
      m_warm    = 1'b0;
      m_drop_pc = '0;
      if (!clk) begin
        check("rst imem_req",   32'(imem_req),   32'd0);
        check("rst pc_ena",     32'(pc_ena),     32'd0);
        check("rst inst_valid", 32'(inst_valid), 32'd0);
        check("rst imem_addr",  imem_addr,       32'd0);
        check("rst inst_out",   inst_out,        32'd0);
        check("rst inst_pc",    inst_pc,         32'd0);
      end
    end else begin
      m_req   = m_warm && (m_drop || (mq.size() < DEPTH));
      m_fetch = m_req && !m_drop;
      m_addr  = !m_req ? 32'd0 : (m_drop ? m_drop_pc : pc_in);
      check("model imem_req",   32'(imem_req),   32'(m_req));
      check("model imem_addr",  imem_addr,       m_addr);
      check("model pc_ena",     32'(pc_ena),     32'(flush || (m_fetch && imem_ack)));
      check("model inst_valid", 32'(inst_valid), 32'(mq.size() != 0));
      if (mq.size() != 0) begin
        check("model inst_pc",  inst_pc,  mq[0].pc);
        check("model inst_out", inst_out, mq[0].inst);
      end
      if (m_drop && imem_ack) begin
        m_drop = 1'b0;
      end else if (m_fetch && flush && !imem_ack) begin
        m_drop    = 1'b1;
        m_drop_pc = pc_in;
      end
      if (flush) begin
        mq.delete();
      end else begin
        if (mq.size() != 0 && inst_ready) void'(mq.pop_front());
        if (m_fetch && imem_ack) mq.push_back('{pc: pc_in, inst: mem_fn(pc_in)});
      end
      m_warm = 1'b1;
    end
  end

  typedef struct {
    logic        flush;
    logic        ready;
    int unsigned lat;
    logic [31:0] target;
    logic        req;
    logic [31:0] addr;
    logic        ena;
    logic        valid;
    logic [31:0] pc;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs[NV];

  initial begin
    logic [31:0] t;
    t = 32'h0040_0100;
    // flush ready lat target | req addr ena valid head_pc
    vecs[0]  = '{1'b0, 1'b1, 0, t,  1'b0, 32'h0,         1'b0, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 1'b1, 0, t,  1'b1, 32'h0040_0000, 1'b1, 1'b0, 32'h0};
    vecs[2]  = '{1'b0, 1'b1, 0, t,  1'b1, 32'h0040_0004, 1'b1, 1'b1, 32'h0040_0000};
    vecs[3]  = '{1'b0, 1'b1, 0, t,  1'b1, 32'h0040_0008, 1'b1, 1'b1, 32'h0040_0004};
    vecs[4]  = '{1'b0, 1'b0, 0, t,  1'b1, 32'h0040_000c, 1'b1, 1'b1, 32'h0040_0008};
    vecs[5]  = '{1'b0, 1'b0, 0, t,  1'b0, 32'h0,         1'b0, 1'b1, 32'h0040_0008};
    vecs[6]  = '{1'b0, 1'b0, 0, t,  1'b0, 32'h0,         1'b0, 1'b1, 32'h0040_0008};
    vecs[7]  = '{1'b0, 1'b1, 0, t,  1'b0, 32'h0,         1'b0, 1'b1, 32'h0040_0008};
    vecs[8]  = '{1'b0, 1'b1, 0, t,  1'b1, 32'h0040_0010, 1'b1, 1'b1, 32'h0040_000c};
    vecs[9]  = '{1'b0, 1'b1, 0, t,  1'b1, 32'h0040_0014, 1'b1, 1'b1, 32'h0040_0010};
    vecs[10] = '{1'b1, 1'b1, 0, t,  1'b1, 32'h0040_0018, 1'b1, 1'b1, 32'h0040_0014};
    vecs[11] = '{1'b0, 1'b1, 0, t,  1'b1, 32'h0040_0100, 1'b1, 1'b0, 32'h0};
    vecs[12] = '{1'b0, 1'b1, 0, t,  1'b1, 32'h0040_0104, 1'b1, 1'b1, 32'h0040_0100};
    vecs[13] = '{1'b0, 1'b1, 3, t,  1'b1, 32'h0040_0108, 1'b0, 1'b1, 32'h0040_0104};
    vecs[14] = '{1'b1, 1'b1, 3, 32'h0040_0200,
                                    1'b1, 32'h0040_0108, 1'b1, 1'b0, 32'h0};
    vecs[15] = '{1'b0, 1'b1, 3, t,  1'b1, 32'h0040_0108, 1'b0, 1'b0, 32'h0};
    vecs[16] = '{1'b0, 1'b1, 3, t,  1'b1, 32'h0040_0108, 1'b0, 1'b0, 32'h0};
    vecs[17] = '{1'b0, 1'b1, 0, t,  1'b1, 32'h0040_0200, 1'b1, 1'b0, 32'h0};
    vecs[18] = '{1'b0, 1'b1, 0, t,  1'b1, 32'h0040_0204, 1'b1, 1'b1, 32'h0040_0200};

    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    for (int i = 0; i < NV; i++) begin
      flush      = vecs[i].flush;
      inst_ready = vecs[i].ready;
      lat_fixed  = vecs[i].lat;
      target     = vecs[i].target;
      @(negedge clk);
      check($sformatf("vec%0d imem_req", i),   32'(imem_req),   32'(vecs[i].req));
      check($sformatf("vec%0d imem_addr", i),  imem_addr,       vecs[i].addr);
      check($sformatf("vec%0d pc_ena", i),     32'(pc_ena),     32'(vecs[i].ena));
      check($sformatf("vec%0d inst_valid", i), 32'(inst_valid), 32'(vecs[i].valid));
      if (vecs[i].valid) begin
        check($sformatf("vec%0d inst_pc", i),  inst_pc,  vecs[i].pc);
        check($sformatf("vec%0d inst_out", i), inst_out, mem_fn(vecs[i].pc));
      end
      @(posedge clk);
      #1;
    end

    // Asynchronous reset in the middle of a request, away from any edge.
    flush = 1'b0;
    check("pre-reset imem_req", 32'(imem_req), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("async rst imem_req",   32'(imem_req),   32'd0);
    check("async rst pc_ena",     32'(pc_ena),     32'd0);
    check("async rst inst_valid", 32'(inst_valid), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    inst_ready = 1'b1;
    @(negedge clk);
    check("post-rst idle req", 32'(imem_req), 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("post-rst first req",  32'(imem_req), 32'd1);
    check("post-rst first addr", imem_addr,     PC0);

    // Randomized traffic against the model.
    rand_mode = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk);
      #1;
      flush      = ($urandom_range(0, 11) == 0);
      inst_ready = ($urandom_range(0, 3) != 0);
      target     = PC0 + (32'($urandom_range(0, 1023)) << 2);
      if ($urandom_range(0, 599) == 0) begin
        #2 rst = 1'b0;
        #1;
        check("rand async rst imem_req", 32'(imem_req), 32'd0);
        check("rand async rst pc_ena",   32'(pc_ena),   32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
      end
    end

    flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
